// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the fsm_seq serial-stream blocks.
// State encodings and a counter-width helper.
package fsm_seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Bits needed to count down from w-1; never narrower than one bit
  function automatic int ctr_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_bit_ctr.sv
// Loadable down-counter with a zero flag.
// Load has priority; decrement stops at zero.
module seq_bit_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  // Count register: reload, or step down while enabled and nonzero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the bit-serial detectors.
// Valid/ready word input, one bit out per enabled clock.
module seq_serializer
  import fsm_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             dout,
  output logic             dout_vld,
  output logic             dout_last,
  output logic             busy
);

  localparam int CW = ctr_w(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shift;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             shifting;
  logic             accept;
  logic             ctr_dec;

  assign shifting = (state == ST_SHIFT);

  // Ready in IDLE, or on the last bit so the next word follows gap-free
  assign s_ready = !rst && en && (!shifting || cnt_zero);
  assign accept  = s_valid && s_ready;
  assign ctr_dec = en && shifting && !cnt_zero;

  assign sreg_shift = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                : {1'b0, sreg[WIDTH-1:1]};

  // Outputs come straight from state/shift/counter registers
  assign dout      = shifting && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign dout_vld  = shifting;
  assign dout_last = shifting && cnt_zero;
  assign busy      = shifting;

  seq_bit_ctr #(
    .W(CW)
  ) u_bit_ctr (
    .clk     (clk),
    .rst     (rst),
    .en      (ctr_dec),
    .load    (accept),
    .load_val(LAST_IDX),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  // Control FSM and shift register; en=0 freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
    end else if (en) begin
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            sreg  <= s_data;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!cnt_zero) begin
            sreg <= sreg_shift;
          end else if (s_valid) begin
            sreg <= s_data;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer.
// Two instances: MSB-first and LSB-first, shared clk/rst/en.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;

  logic [7:0] m_data  = '0;
  logic       m_valid = 1'b0;
  logic       m_ready, m_dout, m_vld, m_last, m_busy;

  logic [7:0] l_data  = '0;
  logic       l_valid = 1'b0;
  logic       l_ready, l_dout, l_vld, l_last, l_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .en(en),
    .s_data(m_data), .s_valid(m_valid), .s_ready(m_ready),
    .dout(m_dout), .dout_vld(m_vld), .dout_last(m_last),
    .busy(m_busy)
  );

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .en(en),
    .s_data(l_data), .s_valid(l_valid), .s_ready(l_ready),
    .dout(l_dout), .dout_vld(l_vld), .dout_last(l_last),
    .busy(l_busy)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    m_valid = 1'b1; m_data = 8'h5A;
    #1;
    n_checks++;
    if (m_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=0", m_ready);
    end
    tick(); tick();
    m_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({m_dout, m_vld, m_last, m_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outs got=%b exp=0000",
               {m_dout, m_vld, m_last, m_busy});
    end
    n_checks++;
    if ({l_dout, l_vld, l_last, l_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outs_lsb got=%b exp=0000",
               {l_dout, l_vld, l_last, l_busy});
    end
    n_checks++;
    if (m_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready got=%b exp=1", m_ready);
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    m_data = w; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({m_dout, m_vld, m_last, m_ready} !==
          {w[7-i], 1'b1, 1'(i == 7), 1'(i == 7)}) begin
        n_fail++;
        $display("FAIL single bit%0d got=%b exp=%b", i,
                 {m_dout, m_vld, m_last, m_ready},
                 {w[7-i], 1'b1, 1'(i == 7), 1'(i == 7)});
      end
      tick();
    end
    n_checks++;
    if ({m_vld, m_busy, m_dout} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_idle got=%b exp=000",
               {m_vld, m_busy, m_dout});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    w = 16'h817E;
    m_data = 8'h81; m_valid = 1'b1;
    tick();
    m_data = 8'h7E;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) m_valid = 1'b0;
      n_checks++;
      if ({m_dout, m_vld, m_last} !==
          {w[15-i], 1'b1, 1'(i == 7 || i == 15)}) begin
        n_fail++;
        $display("FAIL b2b bit%0d got=%b exp=%b", i,
                 {m_dout, m_vld, m_last},
                 {w[15-i], 1'b1, 1'(i == 7 || i == 15)});
      end
      if (i == 7) begin
        n_checks++;
        if (m_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready got=%b exp=1", m_ready);
        end
      end
      tick();
    end
    n_checks++;
    if (m_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end_vld got=%b exp=0", m_vld);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'b0000_0001;
    l_data = 8'h01; l_valid = 1'b1;
    tick();
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({l_dout, l_vld, l_last} !==
          {exp_bits[i], 1'b1, 1'(i == 7)}) begin
        n_fail++;
        $display("FAIL lsb bit%0d got=%b exp=%b", i,
                 {l_dout, l_vld, l_last},
                 {exp_bits[i], 1'b1, 1'(i == 7)});
      end
      tick();
    end
    n_checks++;
    if (l_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_end_vld got=%b exp=0", l_vld);
    end
  endtask

  task automatic test_stall();
    logic [7:0] w;
    int         cyc;
    int         b;
    w = 8'hC3;
    cyc = 0;
    b = 0;
    m_data = w; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    while (b < 8 && cyc < 20) begin
      en = !(cyc >= 3 && cyc < 6);
      #1;
      n_checks++;
      if ({m_dout, m_vld, m_last} !== {w[7-b], 1'b1, 1'(b == 7)}) begin
        n_fail++;
        $display("FAIL stall cyc%0d got=%b exp=%b", cyc,
                 {m_dout, m_vld, m_last}, {w[7-b], 1'b1, 1'(b == 7)});
      end
      if (!en) begin
        n_checks++;
        if (m_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_ready got=%b exp=0", m_ready);
        end
      end
      if (en) b++;
      cyc++;
      tick();
    end
    en = 1'b1;
    n_checks++;
    if (cyc !== 11) begin
      n_fail++;
      $display("FAIL stall_cycles got=%0d exp=11", cyc);
    end
    n_checks++;
    if (m_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end_vld got=%b exp=0", m_vld);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    m_data = 8'hFF; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (m_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ready got=%b exp=0", m_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({m_dout, m_vld, m_last, m_busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_outs got=%b exp=0000",
               {m_dout, m_vld, m_last, m_busy});
    end
    w = 8'h0F;
    m_data = w; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({m_dout, m_vld, m_last} !== {w[7-i], 1'b1, 1'(i == 7)}) begin
        n_fail++;
        $display("FAIL rst_after bit%0d got=%b exp=%b", i,
                 {m_dout, m_vld, m_last}, {w[7-i], 1'b1, 1'(i == 7)});
      end
      tick();
    end
  endtask

  task automatic test_detector();
    logic [7:0] w;
    logic [7:0] exp_det;
    logic [3:0] h;
    logic       det;
    w = 8'b1010_0010;
    exp_det = 8'b1000_0100;
    h = 4'b1111;
    m_data = w; m_valid = 1'b1;
    tick();
    m_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (en && m_vld) h = {h[2:0], m_dout};
      det = (h[2:0] == 3'b101) || (h == 4'b0010);
      n_checks++;
      if (det !== exp_det[i]) begin
        n_fail++;
        $display("FAIL detect bit%0d got=%b exp=%b dout=%b",
                 i, det, exp_det[i], m_dout);
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_stall();
    test_reset_mid_word();
    test_detector();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
